// File: rtl/mmio_uart_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mmio_uart_ctrl_pkg
// Shared constants for the memory-mapped IO controller: register word offsets
// within the IO region and bit positions inside the STATUS word.
// -----------------------------------------------------------------------------
package mmio_uart_ctrl_pkg;

   // Register word offsets (decoded from mem_adr[ADDR_W+1:2]).
   localparam int unsigned ADR_STATUS   = 0;
   localparam int unsigned ADR_RX_DATA  = 1;
   localparam int unsigned ADR_TX_DATA  = 2;
   localparam int unsigned ADR_CYCLE    = 4;
   localparam int unsigned ADR_INSTR    = 5;
   localparam int unsigned ADR_CNT_RST  = 6;
   localparam int unsigned ADR_IRQ_EN   = 7;
   localparam int unsigned ADR_STAT_CLR = 8;

   // STATUS word layout.
   localparam int unsigned ST_TX_NOT_FULL  = 0;
   localparam int unsigned ST_RX_NOT_EMPTY = 1;
   localparam int unsigned ST_TX_DROP      = 2;
   localparam int unsigned ST_TX_CNT_LSB   = 8;
   localparam int unsigned ST_RX_CNT_LSB   = 16;
   localparam int unsigned ST_CNT_W        = 8;

endpackage

// File: rtl/mmio_uart_ctrl_if.sv
// -----------------------------------------------------------------------------
// mmio_uart_ctrl_if
// CPU memory-stage side of the IO controller.
//   io_sel  access targets the IO region this cycle
//   rd_en   load request (qualified by io_sel)
//   wea     byte write enables (any bit set with io_sel = store)
//   adr     word address
//   din     store data
//   dout    registered load data, back to the core's load mux
// master = the core, slave = the IO controller.
// -----------------------------------------------------------------------------
interface mmio_uart_ctrl_if #(
   parameter int unsigned ADDR_W = 5,
   parameter int unsigned XLEN   = 32
);
   logic              io_sel;
   logic              rd_en;
   logic [3:0]        wea;
   logic [ADDR_W-1:0] adr;
   logic [XLEN-1:0]   din;
   logic [XLEN-1:0]   dout;

   modport master (output io_sel, rd_en, wea, adr, din, input dout);
   modport slave  (input io_sel, rd_en, wea, adr, din, output dout);
endinterface

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with a registered occupancy count.
//   clk, rst  clock / asynchronous active-low reset (empties the FIFO)
//   push      write wdata; accepted when not full, or when a pop happens
//             in the same cycle
//   pop       remove head entry; ignored while empty
//   full      count == DEPTH
//   empty     count == 0
//   count     entries held, width clog2(DEPTH)+1
//   head      oldest entry (undefined while empty)
// DEPTH must be a power of two so the pointers wrap by natural overflow.
// -----------------------------------------------------------------------------
module sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic                   pop,
   input  logic [WIDTH-1:0]       wdata,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count,
   output logic [WIDTH-1:0]       head
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CW    = PTR_W + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             do_push, do_pop;

   assign full    = (count_q == CW'(DEPTH));
   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign head    = mem_q[rd_ptr_q];

   // When full, a same-cycle pop frees the slot the push is about to overwrite;
   // the popped value has already been consumed combinationally from head.
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge value of its inputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // NOTE: storage is deliberately not reset; the pointers define which
   // entries are valid, so resetting the array would only cost flops.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata;
   end

endmodule

// File: rtl/mmio_uart_ctrl.sv
// -----------------------------------------------------------------------------
// mmio_uart_ctrl
// Memory-mapped IO controller for the Riscv151 SoC (0x8000_0000 region).
//   clk, rst     clock / asynchronous active-low reset
//   bus          CPU access port (io_sel, rd_en, wea, adr, din -> dout)
//   instr_valid  one-cycle pulse per retired instruction
//   tx_data/tx_valid/tx_ready  byte stream to the UART transmitter
//   rx_data/rx_valid/rx_ready  byte stream from the UART receiver
//   irq          RX interrupt: irq_en & RX FIFO non-empty
// Loads return one cycle later in dout, reflecting state in the request
// cycle; an RX_DATA load pops the RX FIFO on that same edge.
// -----------------------------------------------------------------------------
module mmio_uart_ctrl
   import mmio_uart_ctrl_pkg::*;
#(
   parameter int unsigned XLEN       = 32,
   parameter int unsigned ADDR_W     = 5,
   parameter int unsigned FIFO_DEPTH = 8,
   parameter int unsigned CNT_W      = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   mmio_uart_ctrl_if.slave      bus,
   input  logic                 instr_valid,
   output logic [7:0]           tx_data,
   output logic                 tx_valid,
   input  logic                 tx_ready,
   input  logic [7:0]           rx_data,
   input  logic                 rx_valid,
   output logic                 rx_ready,
   output logic                 irq
);

   localparam int unsigned FIFO_CW = $clog2(FIFO_DEPTH) + 1;

   // Access decode
   logic [ADDR_W-1:0] adr;
   logic              acc_rd, acc_wr;
   logic              tx_push, rx_pop, cnt_clr, irq_en_wr, stat_clr;

   assign adr       = bus.adr;
   assign acc_rd    = bus.io_sel & bus.rd_en;
   assign acc_wr    = bus.io_sel & (|bus.wea);
   assign tx_push   = acc_wr & bus.wea[0] & (adr == ADDR_W'(ADR_TX_DATA));
   assign cnt_clr   = acc_wr & (adr == ADDR_W'(ADR_CNT_RST));
   assign irq_en_wr = acc_wr & (adr == ADDR_W'(ADR_IRQ_EN));
   assign stat_clr  = acc_wr & (adr == ADDR_W'(ADR_STAT_CLR));

   // Only the low byte of store data is ever consumed.
   logic unused_din;
   assign unused_din = ^bus.din[XLEN-1:8];

   // FIFOs
   logic               tx_full, tx_empty, tx_pop;
   logic [FIFO_CW-1:0] tx_count;
   logic [7:0]         tx_head;
   logic               rx_full, rx_empty, rx_push;
   logic [FIFO_CW-1:0] rx_count;
   logic [7:0]         rx_head;

   assign tx_pop  = ~tx_empty & tx_ready;
   assign rx_push = rx_valid & ~rx_full;
   assign rx_pop  = acc_rd & (adr == ADDR_W'(ADR_RX_DATA)) & ~rx_empty;

   sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (tx_push),
      .pop   (tx_pop),
      .wdata (bus.din[7:0]),
      .full  (tx_full),
      .empty (tx_empty),
      .count (tx_count),
      .head  (tx_head)
   );

   sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (rx_push),
      .pop   (rx_pop),
      .wdata (rx_data),
      .full  (rx_full),
      .empty (rx_empty),
      .count (rx_count),
      .head  (rx_head)
   );

   // Architectural registers
   logic [XLEN-1:0]  dout_q, dout_d;
   logic [CNT_W-1:0] cycle_q, cycle_d;
   logic [CNT_W-1:0] instr_q, instr_d;
   logic             irq_en_q, irq_en_d;
   logic             tx_drop_q, tx_drop_d;

   logic [XLEN-1:0] status;
   logic [XLEN-1:0] rd_val;

   always_comb begin
      status                                   = '0;
      status[ST_TX_NOT_FULL]                   = ~tx_full;
      status[ST_RX_NOT_EMPTY]                  = ~rx_empty;
      status[ST_TX_DROP]                       = tx_drop_q;
      status[ST_TX_CNT_LSB +: ST_CNT_W]        = ST_CNT_W'(tx_count);
      status[ST_RX_CNT_LSB +: ST_CNT_W]        = ST_CNT_W'(rx_count);
   end

   always_comb begin
      rd_val = '0;
      case (adr)
         ADDR_W'(ADR_STATUS):  rd_val = status;
         ADDR_W'(ADR_RX_DATA): rd_val = rx_empty ? '0 : XLEN'(rx_head);
         ADDR_W'(ADR_CYCLE):   rd_val = XLEN'(cycle_q);
         ADDR_W'(ADR_INSTR):   rd_val = XLEN'(instr_q);
         ADDR_W'(ADR_IRQ_EN):  rd_val = XLEN'(irq_en_q);
         default:              rd_val = '0;
      endcase
   end

   always_comb begin
      dout_d    = acc_rd ? rd_val : dout_q;
      // A clear wins over an increment in the same cycle.
      cycle_d   = cnt_clr ? '0 : cycle_q + CNT_W'(1);
      instr_d   = cnt_clr ? '0 : instr_q + CNT_W'(instr_valid);
      irq_en_d  = irq_en_wr ? bus.din[0] : irq_en_q;
      // A fresh drop in the same cycle as a clear stays visible.
      tx_drop_d = tx_drop_q;
      if (stat_clr) tx_drop_d = 1'b0;
      if (tx_push & tx_full & ~tx_pop) tx_drop_d = 1'b1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         dout_q    <= '0;
         cycle_q   <= '0;
         instr_q   <= '0;
         irq_en_q  <= 1'b0;
         tx_drop_q <= 1'b0;
      end else begin
         dout_q    <= dout_d;
         cycle_q   <= cycle_d;
         instr_q   <= instr_d;
         irq_en_q  <= irq_en_d;
         tx_drop_q <= tx_drop_d;
      end
   end

   assign bus.dout = dout_q;
   assign tx_data  = tx_head;
   assign tx_valid = ~tx_empty;
   assign rx_ready = ~rx_full;
   assign irq      = irq_en_q & ~rx_empty;

endmodule

// File: tb/tb_mmio_uart_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mmio_uart_ctrl
// Directed scenarios followed by randomized traffic, checked every cycle
// against a queue-based reference model of the register map. A second
// instance built with CNT_W = 8 exercises counter wrap.
// -----------------------------------------------------------------------------
module tb_mmio_uart_ctrl;

   localparam int XLEN   = 32;
   localparam int ADDR_W = 5;
   localparam int DEPTH  = 8;
   localparam int CNT_W  = 32;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic       instr_valid, tx_ready, rx_valid;
   logic [7:0] rx_data;
   logic [7:0] tx_data;
   logic       tx_valid, rx_ready, irq;

   logic [7:0] tx_data8;
   logic       tx_valid8, rx_ready8, irq8;
   logic       tx_ready8 = 1'b0;
   logic       rx_valid8 = 1'b0;
   logic [7:0] rx_data8  = 8'h00;

   mmio_uart_ctrl_if #(.ADDR_W(ADDR_W), .XLEN(XLEN)) bus ();
   mmio_uart_ctrl_if #(.ADDR_W(ADDR_W), .XLEN(XLEN)) bus8 ();

   mmio_uart_ctrl #(.XLEN(XLEN), .ADDR_W(ADDR_W), .FIFO_DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus.slave),
      .instr_valid (instr_valid),
      .tx_data     (tx_data),
      .tx_valid    (tx_valid),
      .tx_ready    (tx_ready),
      .rx_data     (rx_data),
      .rx_valid    (rx_valid),
      .rx_ready    (rx_ready),
      .irq         (irq)
   );

   mmio_uart_ctrl #(.XLEN(XLEN), .ADDR_W(ADDR_W), .FIFO_DEPTH(DEPTH), .CNT_W(8)) dut8 (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus8.slave),
      .instr_valid (instr_valid),
      .tx_data     (tx_data8),
      .tx_valid    (tx_valid8),
      .tx_ready    (tx_ready8),
      .rx_data     (rx_data8),
      .rx_valid    (rx_valid8),
      .rx_ready    (rx_ready8),
      .irq         (irq8)
   );

   // ---------------- scoreboard counters ----------------
   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   byte unsigned tx_m[$];
   byte unsigned rx_m[$];
   bit           drop_m, irq_en_m;
   longint       cyc_m, ins_m, cyc8_m;
   logic [31:0]  dout_m, dout8_m;
   localparam longint CNT_MOD = longint'(1) << CNT_W;

   task automatic model_reset();
      tx_m.delete();
      rx_m.delete();
      drop_m   = 0;
      irq_en_m = 0;
      cyc_m    = 0;
      ins_m    = 0;
      cyc8_m   = 0;
      dout_m   = '0;
      dout8_m  = '0;
   endtask

   function automatic logic [31:0] model_read(input int a);
      logic [31:0] s;
      case (a)
         0: begin
            s        = '0;
            s[0]     = tx_m.size() < DEPTH;
            s[1]     = rx_m.size() > 0;
            s[2]     = drop_m;
            s[15:8]  = 8'(tx_m.size());
            s[23:16] = 8'(rx_m.size());
            return s;
         end
         1:       return (rx_m.size() > 0) ? {24'h0, rx_m[0]} : 32'h0;
         4:       return 32'(cyc_m);
         5:       return 32'(ins_m);
         7:       return {31'h0, irq_en_m};
         default: return 32'h0;
      endcase
   endfunction

   // One clock edge of the register map, from the inputs presented this cycle.
   task automatic model_step();
      int          a;
      bit          wr, rd, tx_pop, tx_push, tx_fits, rx_push, rx_pop;
      logic [31:0] rv;
      if (!rst) begin
         model_reset();
         return;
      end
      a       = int'(bus.adr);
      wr      = bus.io_sel && (bus.wea != 4'h0);
      rd      = bus.io_sel && bus.rd_en;
      rv      = model_read(a);
      tx_pop  = (tx_m.size() > 0) && tx_ready;
      tx_push = wr && (a == 2) && bus.wea[0];
      tx_fits = (tx_m.size() < DEPTH) || tx_pop;
      rx_push = rx_valid && (rx_m.size() < DEPTH);
      rx_pop  = rd && (a == 1) && (rx_m.size() > 0);

      if (tx_pop) void'(tx_m.pop_front());
      if (tx_push && tx_fits) tx_m.push_back(bus.din[7:0]);
      if (wr && a == 8) drop_m = 0;
      if (tx_push && !tx_fits) drop_m = 1;
      if (rx_pop) void'(rx_m.pop_front());
      if (rx_push) rx_m.push_back(rx_data);
      if (wr && a == 6) begin
         cyc_m = 0;
         ins_m = 0;
      end else begin
         cyc_m = (cyc_m + 1) % CNT_MOD;
         if (instr_valid) ins_m = (ins_m + 1) % CNT_MOD;
      end
      if (wr && a == 7) irq_en_m = bus.din[0];
      if (rd) dout_m = rv;

      if (bus8.io_sel && bus8.rd_en) dout8_m = (int'(bus8.adr) == 4) ? 32'(cyc8_m) : 32'h0;
      cyc8_m = (cyc8_m + 1) % 256;
   endtask

   // ---------------- per-cycle compare process ----------------
   always @(negedge clk) begin
      if (chk_en) begin
         check("tx_valid", {31'h0, tx_valid}, {31'h0, tx_m.size() > 0});
         if (tx_m.size() > 0) check("tx_data", {24'h0, tx_data}, {24'h0, tx_m[0]});
         check("rx_ready", {31'h0, rx_ready}, {31'h0, rx_m.size() < DEPTH});
         check("irq", {31'h0, irq}, {31'h0, irq_en_m && rx_m.size() > 0});
         check("dout", bus.dout, dout_m);
         check("dout8", bus8.dout, dout8_m);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic idle();
      bus.io_sel = 1'b0;
      bus.rd_en  = 1'b0;
      bus.wea    = 4'h0;
      bus.adr    = '0;
      bus.din    = '0;
   endtask

   task automatic wr_reg(input int a, input logic [31:0] d);
      bus.io_sel = 1'b1;
      bus.wea    = 4'hF;
      bus.adr    = ADDR_W'(a);
      bus.din    = d;
      tick();
      idle();
   endtask

   task automatic rd_reg(input int a);
      bus.io_sel = 1'b1;
      bus.rd_en  = 1'b1;
      bus.adr    = ADDR_W'(a);
      tick();
      idle();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no finish, expected finish before time limit");
      $fatal(1);
   end

   initial begin
      idle();
      bus8.io_sel = 1'b0;
      bus8.rd_en  = 1'b0;
      bus8.wea    = 4'h0;
      bus8.adr    = '0;
      bus8.din    = '0;
      instr_valid = 1'b0;
      tx_ready    = 1'b0;
      rx_valid    = 1'b0;
      rx_data     = 8'h00;
      model_reset();
      repeat (3) tick();
      rst    = 1'b1;
      chk_en = 1'b1;

      // Reset state
      rd_reg(0);
      check("reset_status", bus.dout, 32'h0000_0001);
      check("reset_tx_valid", {31'h0, tx_valid}, 32'h0);
      check("reset_rx_ready", {31'h0, rx_ready}, 32'h1);
      check("reset_irq", {31'h0, irq}, 32'h0);

      // Two bytes queued, then drained back to back
      wr_reg(2, 32'h41);
      wr_reg(2, 32'h42);
      rd_reg(0);
      check("tx_two_status", bus.dout, 32'h0000_0201);
      check("tx_head_41", {24'h0, tx_data}, 32'h41);
      tx_ready = 1'b1;
      tick();
      check("tx_head_42", {24'h0, tx_data}, 32'h42);
      tick();
      check("tx_drained", {31'h0, tx_valid}, 32'h0);
      tx_ready = 1'b0;

      // Overflow, sticky drop, clear, push-while-full with pop
      for (int i = 0; i < DEPTH; i++) wr_reg(2, 32'h50 + i);
      wr_reg(2, 32'h99);
      rd_reg(0);
      check("tx_drop_status", bus.dout, 32'h0000_0804);
      wr_reg(8, 32'h0);
      rd_reg(0);
      check("stat_clr_status", bus.dout, 32'h0000_0800);
      tx_ready   = 1'b1;
      bus.io_sel = 1'b1;
      bus.wea    = 4'h1;
      bus.adr    = ADDR_W'(2);
      bus.din    = 32'hAA;
      tick();
      idle();
      tx_ready = 1'b0;
      rd_reg(0);
      check("full_push_pop_status", bus.dout, 32'h0000_0800);
      tx_ready = 1'b1;
      repeat (DEPTH + 2) tick();
      tx_ready = 1'b0;

      // RX fill, IRQ, ordered reads, read while empty
      for (int i = 0; i < DEPTH; i++) begin
         rx_valid = 1'b1;
         rx_data  = 8'(8'h10 + i);
         tick();
      end
      rx_valid = 1'b0;
      check("rx_full_ready", {31'h0, rx_ready}, 32'h0);
      wr_reg(7, 32'h1);
      check("irq_on", {31'h0, irq}, 32'h1);
      for (int i = 0; i < DEPTH; i++) begin
         rd_reg(1);
         check("rx_pop_data", bus.dout, 32'h10 + i);
      end
      check("irq_off", {31'h0, irq}, 32'h0);
      rd_reg(1);
      check("rx_empty_read", bus.dout, 32'h0);

      // Counters
      wr_reg(6, 32'h0);
      for (int i = 0; i < 20; i++) begin
         instr_valid = (i % 4 == 0);
         tick();
      end
      instr_valid = 1'b0;
      rd_reg(5);
      check("instr_count_5", bus.dout, 32'h5);
      wr_reg(6, 32'h0);
      rd_reg(5);
      check("instr_cleared", bus.dout, 32'h0);
      rd_reg(4);
      check("cycle_after_clr", bus.dout, 32'h1);

      // Asynchronous reset with bytes queued
      for (int i = 0; i < 3; i++) wr_reg(2, 32'hC0 + i);
      check("tx_before_reset", {31'h0, tx_valid}, 32'h1);
      #2;
      rst = 1'b0;
      model_reset();
      #1;
      check("async_tx_valid", {31'h0, tx_valid}, 32'h0);
      check("async_rx_ready", {31'h0, rx_ready}, 32'h1);
      tick();
      tick();
      rst = 1'b1;
      rd_reg(0);
      check("post_reset_status", bus.dout, 32'h0000_0001);

      // Counter wrap on the CNT_W = 8 instance
      for (int i = 0; i < 400 && cyc8_m != 255; i++) tick();
      bus8.io_sel = 1'b1;
      bus8.rd_en  = 1'b1;
      bus8.adr    = ADDR_W'(4);
      tick();
      check("cnt8_ff", bus8.dout, 32'h0000_00FF);
      tick();
      check("cnt8_wrap", bus8.dout, 32'h0000_0000);
      bus8.io_sel = 1'b0;
      bus8.rd_en  = 1'b0;

      // Randomized traffic
      for (int n = 0; n < 3000; n++) begin
         bus.io_sel  = 1'($urandom_range(0, 1));
         bus.rd_en   = 1'($urandom_range(0, 1));
         bus.wea     = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
         bus.adr     = ($urandom_range(0, 7) == 0) ? ADDR_W'($urandom) : ADDR_W'($urandom_range(0, 9));
         bus.din     = $urandom;
         tx_ready    = 1'($urandom_range(0, 1));
         rx_valid    = 1'($urandom_range(0, 1));
         rx_data     = 8'($urandom);
         instr_valid = 1'($urandom_range(0, 1));
         tick();
      end
      idle();
      tx_ready    = 1'b0;
      rx_valid    = 1'b0;
      instr_valid = 1'b0;
      tick();
      @(negedge clk);
      #1;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mmio_uart_ctrl.md
Name: mmio_uart_ctrl

Overview:
- Parametrised memory-mapped I/O controller for the Riscv151 SoC; successor to the fixed-function IO block behind the 0x8000_0000 region.
- Decodes CPU word accesses to UART data/status, cycle and instruction counters, and IRQ control.
- Adds TX/RX byte FIFOs of configurable depth, sticky error status and an RX interrupt.
- Sits between the core's memory stage (address/write-data/byte-enables) and the on-chip uart (ready/valid byte ports); its read data feeds the core's load mux.

Parameters:
- XLEN, 32, CPU data width.
- ADDR_W, 5, word-address bits decoded (driven from mem_adr[ADDR_W+1:2]).
- FIFO_DEPTH, 8, entries per TX and RX FIFO; power of two, >= 2.
- CNT_W, 32, counter width; must be <= XLEN, zero-extended on read.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- io_sel  in  1  access targets the IO region this cycle.
- rd_en  in  1  load request (qualified by io_sel).
- wea  in  4  byte write enables (any bit set with io_sel = write).
- adr  in  ADDR_W  word address.
- din  in  XLEN  store data.
- dout  out  XLEN  registered read data.
- instr_valid  in  1  one-cycle pulse per retired instruction.
- tx_data  out  8  byte to UART transmitter.
- tx_valid  out  1  TX FIFO non-empty.
- tx_ready  in  1  UART accepts tx_data.
- rx_data  in  8  byte from UART receiver.
- rx_valid  in  1  received byte available.
- rx_ready  out  1  RX FIFO not full.
- irq  out  1  RX interrupt.

Behaviour:
- Reset: FIFOs empty, counters 0, sticky bits 0, irq_en 0, dout 0; hence tx_valid 0, rx_ready 1, irq 0.
- Register map (word adr), all other addresses read 0 and ignore writes:
  - 0 STATUS RO: bit0 tx_not_full, bit1 rx_not_empty, bit2 tx_drop (sticky); [15:8] TX count; [23:16] RX count.
  - 1 RX_DATA RO: {24'b0, head byte}; read pops; read while empty returns 0, no pop.
  - 2 TX_DATA WO: write with wea[0] pushes din[7:0]; write while full (and no same-cycle pop) is dropped and sets tx_drop.
  - 4 CYCLE RO; 5 INSTR RO.
  - 6 CNT_RST WO: any write clears both counters.
  - 7 IRQ_EN RW: bit0.
  - 8 STAT_CLR WO: any write clears tx_drop.
- Read latency 1: dout updates on the edge after io_sel&rd_en and holds until the next read; the value reflects state in the request cycle. RX pop commits on that same edge.
- Simultaneous rd_en and write: both are honoured.
- FIFO rules: push accepted if !full or a pop occurs in the same cycle. Push on empty with no pop does not bypass; tx_valid rises the following cycle. Pointers wrap modulo FIFO_DEPTH; count width is clog2(FIFO_DEPTH)+1.
- TX: pop on tx_valid&tx_ready; tx_data is the head entry, stable while tx_valid&!tx_ready.
- RX: push on rx_valid&rx_ready; rx_ready = !rx_full, from registered state.
- Counters: CYCLE increments every cycle, INSTR on instr_valid; both wrap at 2^CNT_W. A CNT_RST write wins over an increment (value 0 next cycle; counting resumes the cycle after).
- irq = irq_en & rx_not_empty, from registered state, with no extra latency beyond FIFO state.
- Reset asserted mid-operation: all state returns to reset values immediately; FIFO contents are discarded.

Decomposition:
- Shared package/defines: register word offsets (ADR_STATUS..ADR_STAT_CLR), STATUS bit positions.
- One sub-module: sync_fifo (WIDTH, DEPTH; push, pop, full, empty, count, head). Instantiated twice with WIDTH = 8.

Test Plan:
- Reset, then read STATUS -> dout = 0x0000_0001 one cycle later; tx_valid = 0, rx_ready = 1, irq = 0.
- Write TX_DATA 0x41, 0x42 with tx_ready = 0 -> STATUS[15:8] = 2. Raise tx_ready -> tx_data 0x41 then 0x42 on consecutive cycles; tx_valid falls.
- Fill TX FIFO to 8 with tx_ready = 0, then write 0x99 -> byte dropped, STATUS = 0x0000_0804. Write STAT_CLR -> bit2 = 0. Write when full with concurrent tx_ready -> accepted, no drop.
- Push RX bytes 0x10..0x17 -> rx_ready = 0 after the 8th. Set IRQ_EN = 1 -> irq = 1. Eight RX_DATA reads -> dout 0x10..0x17 in order. A 9th read -> dout 0, irq = 0.
- Pulse instr_valid 5 times over 20 cycles, then write CNT_RST -> INSTR 0, CYCLE small. Preload a CNT_W = 8 build to 0xFF -> wraps to 0x00.
- Assert rst low mid-TX with 3 bytes queued -> tx_valid = 0 asynchronously; STATUS reads 0x0000_0001 after release.
